alu_writeback_ctrl: RTL and testbench
=====================================

Name: alu_writeback_ctrl

Overview:
- Stage directly downstream of the 16-bit ALU in the multicycle core.
- Captures ALU result, carry and zero, and owns the architectural C and Z flag registers.
- Resolves the conditional-execute rules for ADC/ADZ/NDC/NDZ and drives one register-file write per accepted op, with R7 writes flagged to the PC logic.
- Valid/ready handshake upstream; write port with stall input downstream.

Parameters:
- DW, 16, datapath width of the result.
- AW, 3, register-file address width; the PC is register 2**AW-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  block can accept the op
- in_data  in  DW  ALU out
- in_carry  in  1  ALU carry
- in_zero  in  1  ALU zero
- in_cond  in  2  00 unconditional, 10 execute only if C=1, 01 execute only if Z=1, 11 reserved (treated as 00)
- in_dest  in  AW  destination register
- in_flag_c_en  in  1  op updates C when executed
- in_flag_z_en  in  1  op updates Z when executed
- rf_stall  in  1  register file cannot take a write this cycle
- rf_we  out  1  register write strobe
- rf_addr  out  AW  write address
- rf_data  out  DW  write data
- pc_we  out  1  asserted together with rf_we when rf_addr equals 2**AW-1
- flag_c  out  1  architectural carry flag
- flag_z  out  1  architectural zero flag
- squashed  out  1  one-cycle pulse when a conditional op is not executed

Behaviour:
- Reset (synchronous, active-high, `reset` sampled on the `clk` rising edge):
  - FSM goes to IDLE.
  - rf_we=0, pc_we=0, squashed=0, rf_addr=0, rf_data=0, flag_c=0, flag_z=0, in_ready=1.
  - Reset asserted mid-WRITE drops the pending write. No partial flag update occurs.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch data, carry, zero, dest and the enable bits.
    - Evaluate exec = (cond==10 ? flag_c : cond==01 ? flag_z : 1) using the flags as they were before this op.
    - exec=1 -> WRITE.
    - exec=0 -> SQUASH.
  - WRITE:
    - in_ready=0, rf_we=1, with rf_addr and rf_data driven from the latches.
    - pc_we=1 if dest is all-ones.
    - While rf_stall=1: hold all outputs and stay in WRITE.
    - First cycle with rf_stall=0: the write commits, then update flag_c/flag_z per their enable bits (values from the latched carry/zero) on that same edge, then go to IDLE.
  - SQUASH:
    - in_ready=0, squashed=1 for exactly one cycle.
    - No write, flags unchanged, then IDLE.
- Latency:
  - Op accepted at edge N: rf_we is visible in cycle N+1.
  - Flags are visible one cycle after the non-stalled write cycle.
- Throughput: one op every 2 cycles at best; no back-to-back acceptance.
- Flag dependency: a conditional op accepted right after a flag-writing op sees the updated flags, because IDLE follows the flag update.
- Simultaneous events:
  - in_valid while not in IDLE is ignored; upstream must hold it, and no data is lost because in_ready=0.
  - reset takes priority over everything else.
- rf_data is the latched value and never changes during a stall.

Optional Feature:
- Macro: WB_SQUASH_CNT_EN.
- Defined:
  - Adds output port squash_cnt (16 bits).
  - Reset to 0. Increments on every SQUASH entry and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then unconditional op (data=16'h1234, dest=3, carry=1, c_en=1) -> rf_we=1 at N+1 with addr=3, data=16'h1234; flag_c=1 after the write; pc_we=0.
- With flag_c=0, op cond=10 (data=16'h00FF) -> squashed pulse for 1 cycle, no rf_we, flags unchanged. Then with flag_c=1 the same op -> write occurs.
- Op with zero=1, z_en=1, followed immediately by a cond=01 op -> the second op executes, confirming it uses the updated Z.
- rf_stall held high for 3 cycles during WRITE -> rf_we, addr and data stable for 4 cycles; flags update only after the stall is released; in_ready=0 throughout.
- dest=7, data=16'h0040 -> rf_we=1 and pc_we=1 in the same cycle.
- Reset asserted during a stalled WRITE -> next cycle rf_we=0, flags=0, in_ready=1. With WB_SQUASH_CNT_EN defined, three squashes -> squash_cnt=3, and it is 0 after reset.

Source files
------------

// File: rtl/alu_writeback_ctrl_if.sv
// Handshake and register-file write bundle for alu_writeback_ctrl.
// master: the ALU and register-file side. slave: the writeback controller.
interface alu_writeback_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  // Upstream ALU handshake
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_carry;
  logic          in_zero;
  logic [1:0]    in_cond;
  logic [AW-1:0] in_dest;
  logic          in_flag_c_en;
  logic          in_flag_z_en;

  // Downstream register-file write port
  logic          rf_stall;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          pc_we;

  modport master (
    output in_valid, in_data, in_carry, in_zero, in_cond, in_dest,
           in_flag_c_en, in_flag_z_en, rf_stall,
    input  in_ready, rf_we, rf_addr, rf_data, pc_we
  );

  modport slave (
    input  in_valid, in_data, in_carry, in_zero, in_cond, in_dest,
           in_flag_c_en, in_flag_z_en, rf_stall,
    output in_ready, rf_we, rf_addr, rf_data, pc_we
  );
endinterface

// File: rtl/alu_writeback_ctrl.sv
// ALU writeback controller: latches one ALU result per accepted op, resolves
// conditional execution against the architectural C/Z flags, issues a single
// register-file write (flagging writes to the PC register) and then updates
// the flags.
// Optional: define WB_SQUASH_CNT_EN to add a saturating 16-bit squash counter.
module alu_writeback_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                reset,
  alu_writeback_ctrl_if.slave bus,
  output logic                flag_c,
  output logic                flag_z,
  output logic                squashed
`ifdef WB_SQUASH_CNT_EN
  ,
  output logic [15:0]         squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_SQUASH = 2'd2
  } state_t;

  // The program counter lives in the highest-numbered register.
  localparam logic [AW-1:0] PC_ADDR = '1;

  state_t        r_state;
  state_t        w_next_state;

  logic [DW-1:0] r_data;
  logic [AW-1:0] r_dest;
  logic          r_carry;
  logic          r_zero;
  logic          r_c_en;
  logic          r_z_en;
  logic          r_flag_c;
  logic          r_flag_z;

  logic          w_accept;
  logic          w_exec;
  logic          w_commit;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_commit = (r_state == S_WRITE) && !bus.rf_stall;

  // Condition check against the flags as they stand before the incoming op;
  // the reserved encoding 11 behaves as unconditional.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_exec = 1'b1;
    case (bus.in_cond)
      2'b10:   w_exec = r_flag_c;
      2'b01:   w_exec = r_flag_z;
      default: w_exec = 1'b1;
    endcase
  end

  // State register; reset wins over any pending write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: one op in flight; a write holds while the file stalls.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_valid) w_next_state = w_exec ? S_WRITE : S_SQUASH;
      S_WRITE:  if (!bus.rf_stall) w_next_state = S_IDLE;
      S_SQUASH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the current state only, so outputs hold during stalls.
  always_comb begin
    bus.in_ready = (r_state == S_IDLE);
    bus.rf_we    = (r_state == S_WRITE);
    bus.pc_we    = (r_state == S_WRITE) && (r_dest == PC_ADDR);
    squashed     = (r_state == S_SQUASH);
  end

  assign bus.rf_addr = r_dest;
  assign bus.rf_data = r_data;
  assign flag_c      = r_flag_c;
  assign flag_z      = r_flag_z;

  // Operand capture on acceptance; nothing else can change these mid-write.
  always_ff @(posedge clk) begin
    // NOTE: these data registers are reset because rf_addr/rf_data are
    // visible outputs that must read zero out of reset.
    if (reset) begin
      r_data  <= '0;
      r_dest  <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_c_en  <= 1'b0;
      r_z_en  <= 1'b0;
    end else if (w_accept) begin
      r_data  <= bus.in_data;
      r_dest  <= bus.in_dest;
      r_carry <= bus.in_carry;
      r_zero  <= bus.in_zero;
      r_c_en  <= bus.in_flag_c_en;
      r_z_en  <= bus.in_flag_z_en;
    end
  end

  // Architectural flags change only on the edge where the write commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else if (w_commit) begin
      if (r_c_en) r_flag_c <= r_carry;
      if (r_z_en) r_flag_z <= r_zero;
    end
  end

`ifdef WB_SQUASH_CNT_EN
  logic [15:0] r_squash_cnt;

  // Saturating count of ops that entered SQUASH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_squash_cnt <= '0;
    end else if (w_accept && !w_exec && (r_squash_cnt != 16'hFFFF)) begin
      r_squash_cnt <= r_squash_cnt + 16'd1;
    end
  end

  assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// Directed bench for alu_writeback_ctrl. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_alu_writeback_ctrl;

  logic clk;
  logic reset;
  logic flag_c;
  logic flag_z;
  logic squashed;
`ifdef WB_SQUASH_CNT_EN
  logic [15:0] squash_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  alu_writeback_ctrl_if #(.DW(16), .AW(3)) bus ();

  alu_writeback_ctrl #(.DW(16), .AW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .squashed (squashed)
`ifdef WB_SQUASH_CNT_EN
    ,
    .squash_cnt (squash_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic valid, input logic [1:0] cond, input logic [2:0] dest,
                        input logic [15:0] data, input logic carry, input logic zero,
                        input logic c_en, input logic z_en);
    bus.in_valid     = valid;
    bus.in_cond      = cond;
    bus.in_dest      = dest;
    bus.in_data      = data;
    bus.in_carry     = carry;
    bus.in_zero      = zero;
    bus.in_flag_c_en = c_en;
    bus.in_flag_z_en = z_en;
  endtask

  initial begin
    reset        = 1'b1;
    bus.rf_stall = 1'b0;
    set_op(1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_ready",  32'(bus.in_ready), 32'd1);
    check("rst_we",     32'(bus.rf_we),    32'd0);
    check("rst_pc_we",  32'(bus.pc_we),    32'd0);
    check("rst_squash", 32'(squashed),     32'd0);
    check("rst_addr",   32'(bus.rf_addr),  32'd0);
    check("rst_data",   32'(bus.rf_data),  32'd0);
    check("rst_fc",     32'(flag_c),       32'd0);
    check("rst_fz",     32'(flag_z),       32'd0);
`ifdef WB_SQUASH_CNT_EN
    check("rst_cnt",    32'(squash_cnt),   32'd0);
`endif

    // Unconditional op: write at N+1, flag_c visible after the write cycle
    set_op(1'b1, 2'b00, 3'd3, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("u_we",    32'(bus.rf_we),    32'd1);
    check("u_addr",  32'(bus.rf_addr),  32'd3);
    check("u_data",  32'(bus.rf_data),  32'h1234);
    check("u_pc_we", 32'(bus.pc_we),    32'd0);
    check("u_ready", 32'(bus.in_ready), 32'd0);
    check("u_fc_early", 32'(flag_c),    32'd0);
    tick();
    check("u_we_off", 32'(bus.rf_we),   32'd0);
    check("u_fc",     32'(flag_c),      32'd1);
    check("u_ready2", 32'(bus.in_ready), 32'd1);

    // Clear C with an unconditional carry=0 op
    set_op(1'b1, 2'b00, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("clr_fc", 32'(flag_c), 32'd0);

    // cond=10 with C=0: squashed for one cycle, no write
    set_op(1'b1, 2'b10, 3'd2, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("sq_pulse", 32'(squashed),     32'd1);
    check("sq_we",    32'(bus.rf_we),    32'd0);
    check("sq_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("sq_pulse_end", 32'(squashed),     32'd0);
    check("sq_we2",       32'(bus.rf_we),    32'd0);
    check("sq_ready2",    32'(bus.in_ready), 32'd1);
    check("sq_fc",        32'(flag_c),       32'd0);
    check("sq_fz",        32'(flag_z),       32'd0);

    // Set C, then the same conditional op executes
    set_op(1'b1, 2'b00, 3'd1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("set_fc", 32'(flag_c), 32'd1);
    set_op(1'b1, 2'b10, 3'd2, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("c_we",     32'(bus.rf_we),   32'd1);
    check("c_addr",   32'(bus.rf_addr), 32'd2);
    check("c_data",   32'(bus.rf_data), 32'h00FF);
    check("c_squash", 32'(squashed),    32'd0);
    tick();

    // Z-writing op followed immediately by cond=01; the second op is held
    // on the bus while the first is still writing and must be ignored.
    set_op(1'b1, 2'b00, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    set_op(1'b1, 2'b01, 3'd4, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
    check("z_w1_data", 32'(bus.rf_data), 32'h0000);
    check("z_w1_addr", 32'(bus.rf_addr), 32'd1);
    tick();
    check("z_fz",     32'(flag_z),       32'd1);
    check("z_ready",  32'(bus.in_ready), 32'd1);
    check("z_idle_we", 32'(bus.rf_we),   32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("z_we",     32'(bus.rf_we),   32'd1);
    check("z_addr",   32'(bus.rf_addr), 32'd4);
    check("z_data",   32'(bus.rf_data), 32'hABCD);
    check("z_squash", 32'(squashed),    32'd0);
    tick();
    check("z_fc_keep", 32'(flag_c), 32'd1);
    check("z_fz_keep", 32'(flag_z), 32'd1);

    // Stall for 3 cycles: outputs stable for 4 WRITE cycles, flags late
    set_op(1'b1, 2'b00, 3'd5, 16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.rf_stall = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.rf_stall = 1'b0;
      check($sformatf("st_we_%0d", i),    32'(bus.rf_we),    32'd1);
      check($sformatf("st_addr_%0d", i),  32'(bus.rf_addr),  32'd5);
      check($sformatf("st_data_%0d", i),  32'(bus.rf_data),  32'h5A5A);
      check($sformatf("st_ready_%0d", i), 32'(bus.in_ready), 32'd0);
      check($sformatf("st_fc_%0d", i),    32'(flag_c),       32'd1);
      check($sformatf("st_fz_%0d", i),    32'(flag_z),       32'd1);
      tick();
    end
    check("st_done_we", 32'(bus.rf_we),    32'd0);
    check("st_fc",      32'(flag_c),       32'd0);
    check("st_fz",      32'(flag_z),       32'd0);
    check("st_ready",   32'(bus.in_ready), 32'd1);

    // Write to R7 raises pc_we alongside rf_we
    set_op(1'b1, 2'b00, 3'd7, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("pc_we",   32'(bus.pc_we),   32'd1);
    check("pc_rfwe", 32'(bus.rf_we),   32'd1);
    check("pc_addr", 32'(bus.rf_addr), 32'd7);
    check("pc_data", 32'(bus.rf_data), 32'h0040);
    tick();
    check("pc_we_off", 32'(bus.pc_we), 32'd0);

    // Set Z, then reset in the middle of a stalled write
    set_op(1'b1, 2'b00, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("pre_rst_fz", 32'(flag_z), 32'd1);
    set_op(1'b1, 2'b00, 3'd3, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.rf_stall = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_we", 32'(bus.rf_we), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rf_stall = 1'b0;
    check("mr_we",    32'(bus.rf_we),    32'd0);
    check("mr_pc_we", 32'(bus.pc_we),    32'd0);
    check("mr_fc",    32'(flag_c),       32'd0);
    check("mr_fz",    32'(flag_z),       32'd0);
    check("mr_ready", 32'(bus.in_ready), 32'd1);
    check("mr_data",  32'(bus.rf_data),  32'd0);
    tick();
    check("mr_we2",   32'(bus.rf_we),    32'd0);
    check("mr_fc2",   32'(flag_c),       32'd0);

`ifdef WB_SQUASH_CNT_EN
    check("cnt_after_rst", 32'(squash_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 2'b10, 3'd2, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("cnt_sq_%0d", i), 32'(squashed), 32'd1);
      tick();
    end
    check("cnt_three", 32'(squash_cnt), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("cnt_cleared", 32'(squash_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
